uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte buffer and sequencer that sits directly upstream of the team's UART transmitter. Accepts bytes from a producer in single-cycle writes, holds them in a synchronous FIFO, and feeds the transmitter one byte at a time over its data-valid/active/done handshake. Lets producers burst data without tracking per-byte serial timing.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes; legal range 1..8.
- i_Clock  in  1  sole clock; all logic rising-edge.
- i_Reset  in  1  reset; synchronous and active-high.
- i_Wr_DV  in  1  write strobe; one byte per high cycle.
- i_Wr_Byte  in  8  byte written when i_Wr_DV=1.
- o_Full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- o_Empty  out  1  FIFO holds 0 bytes.
- o_Count  out  DEPTH_LOG2+1  bytes currently stored.
- o_Overflow  out  1  one-cycle pulse: a write was dropped.
- o_Busy  out  1  FIFO non-empty or a byte is in flight in the transmitter.
- o_Tx_DV  out  1  to transmitter data-valid; one-cycle pulse.
- o_Tx_Byte  out  8  to transmitter byte; valid while o_Tx_DV=1.
- i_Tx_Active  in  1  from transmitter active flag.
- i_Tx_Done  in  1  from transmitter done flag; may stay high for more than one cycle.

## Operation
- FIFO: write pointer, read pointer, and count, each registered. Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count is DEPTH_LOG2+1 bits.
- Write with o_Full=0: store i_Wr_Byte, advance the write pointer, count+1.
- Write with o_Full=1: drop the byte and pulse o_Overflow the next cycle. This applies even if a read happens in the same cycle, so a full FIFO is deterministic.
- Simultaneous write and read (not full): count unchanged; both pointers advance.
- o_Full, o_Empty, and o_Count are registered. They reflect the state after the last edge.
- Sequencer FSM, with encodings in the package:
  - S_IDLE: if o_Empty=0 and i_Tx_Active=0, pop the head, register it onto o_Tx_Byte, set o_Tx_DV=1, and go to S_WAIT_ACTIVE.
  - S_WAIT_ACTIVE: o_Tx_DV=0. Wait for i_Tx_Active=1, then go to S_WAIT_DONE. i_Tx_Done is ignored here, which masks the second high cycle of a previous done.
  - S_WAIT_DONE: wait for i_Tx_Done=1, then go to S_IDLE.
  - Undefined encodings go to S_IDLE.
- o_Busy = (o_Empty=0) or (state != S_IDLE), registered.
- Reset mid-operation:
  - The FIFO is emptied and the FSM returns to S_IDLE.
  - o_Tx_DV is forced low.
  - The transmitter has no reset and finishes any byte in progress. The S_IDLE guard on i_Tx_Active prevents a new issue until it is idle.

## Timing
- Reset values:
  - o_Tx_DV=0, o_Tx_Byte=0
  - o_Full=0, o_Empty=1, o_Count=0
  - o_Overflow=0, o_Busy=0
  - FSM=S_IDLE, pointers=0
- Write-to-issue latency into an empty, idle block:
  - i_Wr_DV is sampled at edge k.
  - o_Empty falls after k.
  - o_Tx_DV is high for the one cycle after edge k+1.
- o_Tx_DV is high for exactly one cycle per byte. o_Tx_Byte is held until the next issue.
- Back-to-back bytes:
  - The next o_Tx_DV is issued the cycle after i_Tx_Done is first seen high (S_WAIT_DONE→S_IDLE, then issue).
  - The transmitter is in its idle state by then and accepts it.
  - Minimum gap is 2 cycles beyond the transmitter frame.
- Pop happens at the issue edge, so o_Count drops in the same cycle o_Tx_DV rises.

## Structure
- Package uart_pkg holds:
  - Sequencer state encodings: S_IDLE=2'b00, S_WAIT_ACTIVE=2'b01, S_WAIT_DONE=2'b10.
  - Default DEPTH_LOG2.
  - The shared CLKS_PER_BIT default used by the transmitter and the bench.
- One sub-module, sync_fifo, contains storage, pointers, count, full/empty, and overflow. It is parameterised by width (8) and DEPTH_LOG2.
- uart_tx_fifo contains the sequencer FSM, o_Busy, and the sync_fifo instance.
- The bench instantiates uart_tx_fifo and the transmitter with CLKS_PER_BIT=4.

## Test plan
- Reset check: assert i_Reset for 3 cycles → every output at its reset value; o_Empty=1, o_Count=0.
- Single byte: write 8'hA5 → o_Tx_DV pulses 2 cycles later with o_Tx_Byte=8'hA5. The serial line carries start, 1,0,1,0,0,1,0,1 (LSB first), stop. o_Busy falls after done.
- Burst of 3 bytes: write 8'h01, 8'h02, 8'h03 on consecutive cycles → o_Count peaks at 2. Exactly three o_Tx_DV pulses follow, in order, each issued after the previous i_Tx_Done. There is no double issue during the 2-cycle done.
- Overflow with DEPTH_LOG2=2: write 6 bytes while the transmitter is busy → o_Full=1. o_Overflow pulses for each dropped write, even those coinciding with a pop. Only the first retained bytes are transmitted.
- Pointer wrap: stream 20 bytes 8'h00..8'h13 through a depth-4 FIFO with writes paced at o_Full=0 → all 20 are transmitted in order with no loss.
- Reset mid-frame: assert i_Reset during the data bits of the first of 2 queued bytes → the FIFO is emptied. No new o_Tx_DV is issued until i_Tx_Active=0. A write of 8'h3C after reset then transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: sequencer and transmitter
// state encodings plus the default FIFO depth and bit period.
package uart_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT   = 4;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 4;

  // Sequencer states (uart_tx_fifo)
  localparam logic [1:0] S_IDLE        = 2'b00;
  localparam logic [1:0] S_WAIT_ACTIVE = 2'b01;
  localparam logic [1:0] S_WAIT_DONE   = 2'b10;

  // Transmitter states (uart_tx)
  localparam logic [2:0] TX_IDLE    = 3'd0;
  localparam logic [2:0] TX_START   = 3'd1;
  localparam logic [2:0] TX_DATA    = 3'd2;
  localparam logic [2:0] TX_STOP    = 3'd3;
  localparam logic [2:0] TX_CLEANUP = 3'd4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a one-cycle
// overflow pulse for writes dropped while full.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Wr_DV,
  input  logic [WIDTH-1:0]    i_Wr_Data,
  input  logic                i_Rd_En,
  output logic [WIDTH-1:0]    o_Rd_Data,
  output logic                o_Full,
  output logic                o_Empty,
  output logic                o_Empty_Next,
  output logic [DEPTH_LOG2:0] o_Count,
  output logic                o_Overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic ovf_q, ovf_d;
  logic do_wr, do_rd;

  // Next pointers, occupancy and flags; a write while full is always dropped,
  // even if a read frees a slot on the same edge.
  always_comb begin
    do_wr    = i_Wr_DV && !full_q;
    do_rd    = i_Rd_En && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (do_wr && !do_rd) begin
      count_d = count_q + cnt_t'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - cnt_t'(1);
    end
    // count tops out at exactly 2**DEPTH_LOG2, so the MSB alone marks full
    full_d  = count_d[DEPTH_LOG2];
    empty_d = (count_d == '0);
    ovf_d   = i_Wr_DV && full_q;
  end

  // Control registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_Clock) begin
    if (do_wr && !i_Reset) mem_q[wr_ptr_q] <= i_Wr_Data;
  end

  assign o_Rd_Data    = mem_q[rd_ptr_q];
  assign o_Full       = full_q;
  assign o_Empty      = empty_q;
  assign o_Empty_Next = empty_d;
  assign o_Count      = count_q;
  assign o_Overflow   = ovf_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1, LSB first, CLKS_PER_BIT clocks per bit. Done is
// held high for two cycles at the end of each frame. i_Reset is a power-on
// initialisation only; the FIFO reset does not reach this block.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  // Frame sequencing: start bit, eight data bits, stop bit, cleanup
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = done_q;
    case (state_q)
      TX_IDLE: begin
        serial_d = 1'b1;
        done_d   = 1'b0;
        cnt_d    = '0;
        bit_d    = '0;
        if (i_Tx_DV) begin
          active_d = 1'b1;
          byte_d   = i_Tx_Byte;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        serial_d = 1'b0;
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        serial_d = byte_q[bit_q];
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        serial_d = 1'b1;
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d    = '0;
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = TX_CLEANUP;
        end
      end
      TX_CLEANUP: begin
        done_d  = 1'b1;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus sequencer feeding the UART transmitter one byte at a time
// over its DV/active/done handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Wr_DV,
  input  logic [7:0]          i_Wr_Byte,
  output logic                o_Full,
  output logic                o_Empty,
  output logic [DEPTH_LOG2:0] o_Count,
  output logic                o_Overflow,
  output logic                o_Busy,
  output logic                o_Tx_DV,
  output logic [7:0]          o_Tx_Byte,
  input  logic                i_Tx_Active,
  input  logic                i_Tx_Done
);

  logic [1:0] state_q, state_d;
  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       busy_q, busy_d;
  logic       pop;
  logic [7:0] fifo_head;
  logic       fifo_empty, fifo_empty_next;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Wr_DV      (i_Wr_DV),
    .i_Wr_Data    (i_Wr_Byte),
    .i_Rd_En      (pop),
    .o_Rd_Data    (fifo_head),
    .o_Full       (o_Full),
    .o_Empty      (fifo_empty),
    .o_Empty_Next (fifo_empty_next),
    .o_Count      (o_Count),
    .o_Overflow   (o_Overflow)
  );

  // Issue a byte only when the transmitter is idle, then wait for it to go
  // active before watching done, which masks a lingering done from the last frame.
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !i_Tx_Active) begin
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = fifo_head;
          state_d   = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_ACTIVE: if (i_Tx_Active) state_d = S_WAIT_DONE;
      S_WAIT_DONE:   if (i_Tx_Done)   state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    // busy tracks the post-edge FIFO and FSM state so it aligns with o_Empty
    busy_d = !fifo_empty_next || (state_d != S_IDLE);
  end

  // Sequencer registers
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  assign o_Empty   = fifo_empty;
  assign o_Busy    = busy_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;

endmodule
